// File: rtl/el2_trace_fifo_pkg.sv
// Shared types for the trace FIFO: core trace packet, stored payload and FIFO entry.
// EL2_TRACE_TIMESTAMP_EN adds a 32-bit capture timestamp to each entry.
package el2_trace_fifo_pkg;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_data_t;

  typedef struct packed {
    logic            lost;
`ifdef EL2_TRACE_TIMESTAMP_EN
    logic [31:0]     tstamp;
`endif
    el2_trace_data_t data;
  } el2_trace_fifo_entry_t;

  function automatic el2_trace_data_t el2_trace_strip_valid(input el2_trace_pkt_t pkt);
    el2_trace_data_t d;
    d.trace_rv_i_insn_ip      = pkt.trace_rv_i_insn_ip;
    d.trace_rv_i_address_ip   = pkt.trace_rv_i_address_ip;
    d.trace_rv_i_exception_ip = pkt.trace_rv_i_exception_ip;
    d.trace_rv_i_ecause_ip    = pkt.trace_rv_i_ecause_ip;
    d.trace_rv_i_interrupt_ip = pkt.trace_rv_i_interrupt_ip;
    d.trace_rv_i_tval_ip      = pkt.trace_rv_i_tval_ip;
    return d;
  endfunction

endpackage

// File: rtl/el2_trace_fifo_mem.sv
// Trace FIFO storage: DEPTH entries, one synchronous write port, asynchronous read.
module el2_trace_fifo_mem
  import el2_trace_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  el2_trace_fifo_entry_t wdata,
  input  logic [AW-1:0]         raddr,
  output el2_trace_fifo_entry_t rdata
);

  el2_trace_fifo_entry_t mem [DEPTH];

  // Storage is not reset; the top masks outputs while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/el2_trace_fifo.sv
// el2_trace_fifo: captures core trace packets into a circular FIFO for a valid/ready sink.
// Define EL2_TRACE_TIMESTAMP_EN to store a per-entry capture cycle on out_tstamp.
module el2_trace_fifo
  import el2_trace_fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  input  el2_trace_pkt_t             trace_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output el2_trace_data_t            out_pkt,
  output logic                       out_lost,
  output logic [31:0]                out_tstamp,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  output logic                       overflow,
  input  logic                       clr_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  pending_lost;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  drop;
  el2_trace_fifo_entry_t wdata;
  el2_trace_fifo_entry_t rdata;

  assign out_valid = (fifo_count != '0);
  assign push      = trace_en & trace_in.trace_rv_i_valid_ip;
  assign pop       = out_valid & out_ready;
  // A pop on a full FIFO frees its slot for the same cycle's push.
  assign accept    = push & ((fifo_count < FULL_CNT) | pop);
  assign drop      = push & ~accept;

`ifdef EL2_TRACE_TIMESTAMP_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    wdata      = '0;
    wdata.lost = pending_lost;
    wdata.data = el2_trace_strip_valid(trace_in);
`ifdef EL2_TRACE_TIMESTAMP_EN
    wdata.tstamp = cycle_cnt;
`endif
  end

  el2_trace_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The lost marker rides on the next accepted packet after any run of drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_lost <= 1'b0;
    end else if (drop) begin
      pending_lost <= 1'b1;
    end else if (accept) begin
      pending_lost <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_stats) begin
        drop_cnt <= DROP_CNT_W'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (clr_stats) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end
  end

  assign out_pkt  = out_valid ? rdata.data : '0;
  assign out_lost = out_valid ? rdata.lost : 1'b0;

`ifdef EL2_TRACE_TIMESTAMP_EN
  assign out_tstamp = out_valid ? rdata.tstamp : 32'd0;
`else
  assign out_tstamp = 32'd0;
`endif

endmodule

// File: tb/tb_el2_trace_fifo.sv
// Self-checking bench for el2_trace_fifo: queue-based reference model plus directed literal checks.
// Timestamp expectations follow EL2_TRACE_TIMESTAMP_EN.
module tb_el2_trace_fifo;
  import el2_trace_fifo_pkg::*;

  localparam int DEPTH      = 8;
  localparam int DROP_CNT_W = 16;
  localparam int CW         = $clog2(DEPTH+1);

  logic                  clk;
  logic                  rst;
  logic                  trace_en;
  el2_trace_pkt_t        trace_in;
  logic                  out_valid;
  logic                  out_ready;
  el2_trace_data_t       out_pkt;
  logic                  out_lost;
  logic [31:0]           out_tstamp;
  logic [CW-1:0]         fifo_count;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  overflow;
  logic                  clr_stats;

  int errors = 0;
  int checks = 0;

  el2_trace_fifo #(
    .DEPTH      (DEPTH),
    .DROP_CNT_W (DROP_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trace_en   (trace_en),
    .trace_in   (trace_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pkt    (out_pkt),
    .out_lost   (out_lost),
    .out_tstamp (out_tstamp),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .clr_stats  (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an ordered queue of captured packets plus counters.
  typedef struct {
    logic [102:0] data;
    logic         lost;
    logic [31:0]  ts;
  } m_entry_t;

  m_entry_t    mq[$];
  int          m_drop;
  bit          m_ovf;
  bit          m_pend;
  logic [31:0] m_cyc;
  bit          model_live = 1'b0;
  int          m_n;
  bit          m_pop;
  bit          m_push;
  m_entry_t    m_new;
  el2_trace_data_t m_d;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit vld, input logic [31:0] addr,
                               input bit rdy, input bit clr);
    trace_en                         = en;
    trace_in                         = '0;
    trace_in.trace_rv_i_valid_ip     = vld;
    trace_in.trace_rv_i_address_ip   = addr;
    trace_in.trace_rv_i_insn_ip      = addr * 32'd3 + 32'h13;
    trace_in.trace_rv_i_exception_ip = addr[2];
    trace_in.trace_rv_i_ecause_ip    = addr[6:2];
    trace_in.trace_rv_i_interrupt_ip = addr[3];
    trace_in.trace_rv_i_tval_ip      = ~addr;
    out_ready                        = rdy;
    clr_stats                        = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_drop     = 0;
        m_ovf      = 1'b0;
        m_pend     = 1'b0;
        m_cyc      = 32'd0;
        model_live = 1'b1;
      end else if (model_live) begin
        m_n    = mq.size();
        m_pop  = (m_n > 0) && out_ready;
        m_push = trace_en && trace_in.trace_rv_i_valid_ip;
        if (m_pop) void'(mq.pop_front());
        if (clr_stats) begin
          m_drop = 0;
          m_ovf  = 1'b0;
        end
        if (m_push) begin
          if (m_n < DEPTH || m_pop) begin
            m_d.trace_rv_i_insn_ip      = trace_in.trace_rv_i_insn_ip;
            m_d.trace_rv_i_address_ip   = trace_in.trace_rv_i_address_ip;
            m_d.trace_rv_i_exception_ip = trace_in.trace_rv_i_exception_ip;
            m_d.trace_rv_i_ecause_ip    = trace_in.trace_rv_i_ecause_ip;
            m_d.trace_rv_i_interrupt_ip = trace_in.trace_rv_i_interrupt_ip;
            m_d.trace_rv_i_tval_ip      = trace_in.trace_rv_i_tval_ip;
            m_new.data = m_d;
            m_new.lost = m_pend;
            m_new.ts   = m_cyc;
            mq.push_back(m_new);
            m_pend = 1'b0;
          end else begin
            if (m_drop < (1 << DROP_CNT_W) - 1) m_drop++;
            m_ovf  = 1'b1;
            m_pend = 1'b1;
          end
        end
        m_cyc = m_cyc + 32'd1;
      end
    end
  end

  // Every falling edge: the whole visible state must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        checkOutput("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        checkOutput("fifo_count", 128'(fifo_count), 128'(mq.size()));
        checkOutput("drop_cnt", 128'(drop_cnt), 128'(m_drop));
        checkOutput("overflow", 128'(overflow), 128'(m_ovf));
        if (mq.size() > 0) begin
          checkOutput("out_pkt", 128'(out_pkt), 128'(mq[0].data));
          checkOutput("out_lost", 128'(out_lost), 128'(mq[0].lost));
`ifdef EL2_TRACE_TIMESTAMP_EN
          checkOutput("out_tstamp", 128'(out_tstamp), 128'(mq[0].ts));
`else
          checkOutput("out_tstamp", 128'(out_tstamp), 128'(0));
`endif
        end else begin
          checkOutput("out_pkt_empty", 128'(out_pkt), 128'(0));
          checkOutput("out_lost_empty", 128'(out_lost), 128'(0));
          checkOutput("out_tstamp_empty", 128'(out_tstamp), 128'(0));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 0);
    rst = 1'b0;
    checkOutput("rst_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_count", 128'(fifo_count), 128'(0));
    checkOutput("rst_drop", 128'(drop_cnt), 128'(0));
    checkOutput("rst_ovf", 128'(overflow), 128'(0));
    checkOutput("rst_pkt", 128'(out_pkt), 128'(0));

    // Timestamps: pushes sampled 10 and 17 cycles after reset.
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 1, 32'h50, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 32'h0, 0, 0);
    applyStimulus(1, 1, 32'h54, 0, 0);
`ifdef EL2_TRACE_TIMESTAMP_EN
    checkOutput("tstamp_first", 128'(out_tstamp), 128'(10));
`else
    checkOutput("tstamp_first", 128'(out_tstamp), 128'(0));
`endif
    applyStimulus(1, 0, 32'h0, 1, 0);
`ifdef EL2_TRACE_TIMESTAMP_EN
    checkOutput("tstamp_second", 128'(out_tstamp), 128'(17));
`else
    checkOutput("tstamp_second", 128'(out_tstamp), 128'(0));
`endif
    applyStimulus(1, 0, 32'h0, 1, 0);
    checkOutput("ts_drained", 128'(fifo_count), 128'(0));

    // Basic flow with the sink always ready.
    applyStimulus(1, 1, 32'h100, 1, 0);
    checkOutput("basic_valid", 128'(out_valid), 128'(1));
    checkOutput("basic_addr0", 128'(out_pkt.trace_rv_i_address_ip), 128'(32'h100));
    applyStimulus(1, 1, 32'h104, 1, 0);
    checkOutput("basic_addr1", 128'(out_pkt.trace_rv_i_address_ip), 128'(32'h104));
    checkOutput("basic_count", 128'(fifo_count), 128'(1));
    applyStimulus(1, 1, 32'h108, 1, 0);
    checkOutput("basic_addr2", 128'(out_pkt.trace_rv_i_address_ip), 128'(32'h108));
    checkOutput("basic_lost", 128'(out_lost), 128'(0));
    applyStimulus(1, 0, 32'h0, 1, 0);
    checkOutput("basic_empty", 128'(out_valid), 128'(0));

    // Fill and overflow, then full + simultaneous pop/push.
    for (int i = 0; i < 11; i++) applyStimulus(1, 1, 32'h300 + 32'(4 * i), 0, 0);
    checkOutput("fill_count", 128'(fifo_count), 128'(8));
    checkOutput("fill_drop", 128'(drop_cnt), 128'(3));
    checkOutput("fill_ovf", 128'(overflow), 128'(1));
    checkOutput("fill_head_lost", 128'(out_lost), 128'(0));
    applyStimulus(1, 1, 32'h200, 1, 0);
    checkOutput("fullpp_count", 128'(fifo_count), 128'(8));
    checkOutput("fullpp_drop", 128'(drop_cnt), 128'(3));
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 32'h0, 1, 0);
    checkOutput("lost_addr", 128'(out_pkt.trace_rv_i_address_ip), 128'(32'h200));
    checkOutput("lost_flag", 128'(out_lost), 128'(1));
    applyStimulus(1, 0, 32'h0, 1, 0);

    // Saturation and clear.
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("clr_drop", 128'(drop_cnt), 128'(0));
    checkOutput("clr_ovf", 128'(overflow), 128'(0));
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 32'h600 + 32'(4 * i), 0, 0);
    for (int i = 0; i < 65540; i++) applyStimulus(1, 1, 32'h1000 + 32'(i), 0, 0);
    checkOutput("sat_drop", 128'(drop_cnt), 128'(16'hFFFF));
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("sat_clr_drop", 128'(drop_cnt), 128'(0));
    checkOutput("sat_clr_ovf", 128'(overflow), 128'(0));
    applyStimulus(1, 1, 32'h700, 0, 1);
    checkOutput("clr_vs_drop_cnt", 128'(drop_cnt), 128'(1));
    checkOutput("clr_vs_drop_ovf", 128'(overflow), 128'(1));
    applyStimulus(1, 0, 32'h0, 0, 0);

    // Enable gating, then reset with entries queued.
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 32'h0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h800 + 32'(4 * i), 1, 0);
    checkOutput("en_count", 128'(fifo_count), 128'(0));
    checkOutput("en_drop", 128'(drop_cnt), 128'(1));
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 32'h900 + 32'(4 * i), 0, 0);
    checkOutput("q5_count", 128'(fifo_count), 128'(5));
    checkOutput("q5_head_lost", 128'(out_lost), 128'(1));
    rst = 1'b1;
    applyStimulus(1, 0, 32'h0, 1, 0);
    rst = 1'b0;
    checkOutput("rst2_valid", 128'(out_valid), 128'(0));
    checkOutput("rst2_count", 128'(fifo_count), 128'(0));
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 32'h0, 1, 0);
    checkOutput("rst2_no_stale", 128'(out_valid), 128'(0));
    applyStimulus(1, 1, 32'h400, 0, 0);
    checkOutput("post_rst_addr", 128'(out_pkt.trace_rv_i_address_ip), 128'(32'h400));
    checkOutput("post_rst_lost", 128'(out_lost), 128'(0));
    applyStimulus(1, 0, 32'h0, 1, 0);
    applyStimulus(1, 0, 32'h0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/el2_trace_fifo.md
Name: el2_trace_fifo

Overview:
- Downstream consumer of the core's per-retirement trace packet (el2_trace_pkt_t).
- Captures every valid packet, buffers it in a circular FIFO, and presents it to a debug/trace sink over a valid/ready handshake.
- The core side has no backpressure. When the FIFO is full, packets are dropped and counted, and the next delivered packet carries a "lost" marker.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DROP_CNT_W, 16, width of the saturating dropped-packet counter.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- trace_en  input  1  capture enable; 0 = ignore incoming packets, FIFO still drains
- trace_in  input  104  el2_trace_pkt_t from the core; trace_rv_i_valid_ip = push request
- out_valid  output  1  head entry available
- out_ready  input  1  sink accepts head entry
- out_pkt  output  103  head el2_trace_pkt_t minus the valid bit (el2_trace_data_t)
- out_lost  output  1  one or more packets were dropped immediately before this entry
- out_tstamp  output  32  capture cycle of head entry (see Optional Feature)
- fifo_count  output  $clog2(DEPTH+1)  current occupancy
- drop_cnt  output  DROP_CNT_W  total dropped packets, saturating
- overflow  output  1  sticky; set on first drop; cleared only by rst or clr_stats
- clr_stats  input  1  one-cycle pulse; clears drop_cnt and overflow

Behaviour:
- Reset (rst sampled high at a clk edge):
  - wr_ptr = rd_ptr = 0, fifo_count = 0, out_valid = 0.
  - drop_cnt = 0, overflow = 0, pending_lost = 0.
  - out_pkt, out_lost and out_tstamp read 0 while empty.
  - Reset mid-operation discards all entries; nothing is emitted after reset.
- Push condition: push = trace_en & trace_rv_i_valid_ip.
- Pop condition: pop = out_valid & out_ready.
- Latency: a packet pushed into an empty FIFO at edge N gives out_valid = 1 after edge N. There is no combinational bypass from input to output.
- Outputs are read directly from storage at rd_ptr. They must hold stable while out_valid & !out_ready.
- Accept rule: a push is accepted when count < DEPTH, or when count == DEPTH and pop occurs in the same cycle. A simultaneous pop on a full FIFO frees the slot for that cycle's push.
- Simultaneous push + pop with 0 < count <= DEPTH: count unchanged, both pointers advance.
- Push with count == 0 and out_ready = 1: entry written; pop not possible that cycle; out_valid rises next cycle.
- Drop (push & !accept):
  - drop_cnt increments, saturating at all-ones.
  - overflow is set.
  - pending_lost is set.
- Accepted push:
  - Entry lost bit = pending_lost; pending_lost is then cleared.
  - If a drop and the lost-marked push cannot coincide, the ordering is unambiguous. A single packet per cycle guarantees this.
- clr_stats:
  - Clears drop_cnt and overflow.
  - Does not clear pending_lost or stored lost bits.
  - If clr_stats coincides with a drop, the drop wins: drop_cnt = 1, overflow = 1.
- Pointers: $clog2(DEPTH) bits, wrap naturally, since DEPTH is a power of two.
- fifo_count is maintained as a register, not derived from the pointers, so a full FIFO is distinguishable from an empty one.
- trace_en deasserted: no pushes and no drops are counted. Pops continue.

Optional Feature:
- Macro: EL2_TRACE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter, reset to 0, increments every cycle and wraps at 2^32.
  - The counter value at the push edge is stored per entry and presented on out_tstamp.
  - The first cycle after reset has timestamp 0.
- Undefined:
  - No counter and no timestamp storage.
  - out_tstamp is tied to 0.

Decomposition:
- Additions to el2_pkg:
  - el2_trace_data_t: el2_trace_pkt_t without trace_rv_i_valid_ip, 103 bits.
  - el2_trace_fifo_entry_t: {lost, tstamp[31:0] (ifdef), data el2_trace_data_t}.
- One sub-module, el2_trace_fifo_mem: DEPTH x entry register array, with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointer, count, drop and stats logic stays in the top module.

Test Plan:
- Basic flow: out_ready = 1; push 3 packets with addresses 0x100, 0x104, 0x108 on consecutive cycles -> out_valid rises 1 cycle after first push; packets delivered in order; out_lost = 0; fifo_count peaks at 1.
- Fill and overflow: DEPTH = 8, out_ready = 0; push 11 packets -> fifo_count = 8, drop_cnt = 3, overflow = 1. Then out_ready = 1 and push addr 0x200 -> 8 original entries drain with out_lost = 0, then 0x200 arrives with out_lost = 1.
- Full + simultaneous pop/push: count = 8, out_ready = 1, push in the same cycle -> accepted, count stays 8, drop_cnt unchanged.
- Saturation and clear: force 65540 drops with DROP_CNT_W = 16 -> drop_cnt = 0xFFFF. Pulse clr_stats -> drop_cnt = 0, overflow = 0. clr_stats coincident with a drop -> drop_cnt = 1.
- Enable and reset: trace_en = 0 with valid packets -> count stays 0, drop_cnt stays 0. With 5 entries queued, assert rst for 1 cycle -> out_valid = 0, count = 0, and no stale entry emitted afterward.
- Timestamp (EL2_TRACE_TIMESTAMP_EN): push at cycles 10 and 17 after reset -> out_tstamp = 10 then 17. With the macro undefined -> out_tstamp = 0.
